// File: rtl/sipo_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sipo_loader_pkg
// Brief    : Shared state encodings and default word width for the SIPO path.
// Revision : 1.0 - initial release
// ============================================================================
package sipo_loader_pkg;

    // Default width shared with the downstream parallel-load register
    localparam int c_word_w = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        LOAD  = 2'b10
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sipo_loader_bit_counter.sv
`default_nettype none
// ============================================================================
// Module   : bit_counter
// Brief    : Up-counter with async active-low reset, sync clear and enable.
// Revision : 1.0 - initial release
// ============================================================================
module bit_counter #(
    parameter int cw = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [cw-1:0] cnt
);

    // Clear wins over enable so a restart never counts the dropped bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + cw'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/sipo_loader.sv
`default_nettype none
// ============================================================================
// Module   : sipo_loader
// Brief    : MSB-first serial collector driving a one-cycle parallel load.
// Revision : 1.0 - initial release
// ============================================================================
module sipo_loader
    import sipo_loader_pkg::*;
#(
    parameter int n  = c_word_w,
    parameter int cw = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          sin,
    input  logic          sin_vld,
    output logic [n-1:0]  dout,
    output logic          load,
    output logic          busy,
    output logic [cw-1:0] bit_cnt
);

    localparam logic [cw-1:0] c_last = cw'(n - 1);

    state_t         r_state;
    logic [n-1:0]   r_sr;
    logic [n-1:0]   r_dout;
    logic           r_load;
    logic           r_busy;

    logic           w_accept;
    logic           w_last;
    logic [n-1:0]   w_next_sr;

    // A start on the same edge as a valid bit discards that bit
    assign w_accept  = (r_state == SHIFT) && sin_vld && !start;
    assign w_last    = w_accept && (bit_cnt == c_last);
    assign w_next_sr = {r_sr[n-2:0], sin};

    bit_counter #(
        .cw (cw)
    ) u_bit_counter (
        .clk (clk),
        .rst (rst),
        .clr (start),
        .en  (w_accept),
        .cnt (bit_cnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_sr    <= '0;
            r_dout  <= '0;
            r_load  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_load <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= SHIFT;
                        r_sr    <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (start) begin
                        r_sr <= '0;
                    end else if (w_accept) begin
                        r_sr <= w_next_sr;
                        if (w_last) begin
                            r_state <= LOAD;
                            r_dout  <= w_next_sr;
                            r_load  <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                LOAD: begin
                    if (start) begin
                        r_state <= SHIFT;
                        r_sr    <= '0;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign dout = r_dout;
    assign load = r_load;
    assign busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_sipo_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_sipo_loader
// Brief    : Directed, table-driven self-checking bench for sipo_loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sipo_loader;

    localparam int N  = 16;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          sin;
    logic          sin_vld;
    logic [N-1:0]  dout;
    logic          load;
    logic          busy;
    logic [CW-1:0] bit_cnt;

    always #5 clk = ~clk;

    sipo_loader #(
        .n  (N),
        .cw (CW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .sin     (sin),
        .sin_vld (sin_vld),
        .dout    (dout),
        .load    (load),
        .busy    (busy),
        .bit_cnt (bit_cnt)
    );

    typedef struct {
        logic          start;
        logic          sin;
        logic          vld;
        logic          exp_load;
        logic          exp_busy;
        logic [CW-1:0] exp_cnt;
        logic [N-1:0]  exp_dout;
    } vec_t;

    vec_t        tbl [18];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          edge_no  = 0;
    int          load_edges[$];
    logic [N-1:0] load_douts[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic d, input logic v);
        start   = s;
        sin     = d;
        sin_vld = v;
    endtask

    // Advance one edge and log every load pulse with its edge number and word
    task automatic step();
        @(posedge clk);
        #1;
        edge_no++;
        if (load === 1'b1) begin
            load_edges.push_back(edge_no);
            load_douts.push_back(dout);
        end
    endtask

    task automatic mon_clear();
        edge_no = 0;
        load_edges.delete();
        load_douts.delete();
    endtask

    task automatic send_word(input logic [N-1:0] w);
        for (int i = 0; i < N; i++) begin
            drive(1'b0, w[N-1-i], 1'b1);
            step();
        end
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            drive(1'b0, 1'($urandom), 1'b0);
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N-1:0] w;
        int           bad;

        // Single word 16'hA5C3: start row, 16 bit rows, one trailing idle row
        w = 16'hA5C3;
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 16'h0000};
        for (int k = 1; k <= N; k++) begin
            tbl[k].start    = 1'b0;
            tbl[k].sin      = w[N-k];
            tbl[k].vld      = 1'b1;
            tbl[k].exp_load = (k == N);
            tbl[k].exp_busy = (k != N);
            tbl[k].exp_cnt  = CW'(k);
            tbl[k].exp_dout = (k == N) ? 16'hA5C3 : 16'h0000;
        end
        tbl[17] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd16, 16'hA5C3};

        drive(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        #2;
        chk("reset_state", {9'd0, load, busy, bit_cnt, dout}, 32'd0);
        #10;
        rst = 1'b1;
        step();

        mon_clear();
        for (int r = 0; r < 18; r++) begin
            drive(tbl[r].start, tbl[r].sin, tbl[r].vld);
            step();
            chk($sformatf("single_row%0d", r), {9'd0, load, busy, bit_cnt, dout},
                {9'd0, tbl[r].exp_load, tbl[r].exp_busy, tbl[r].exp_cnt, tbl[r].exp_dout});
        end
        chk("single_load_edge", (load_edges.size() == 1) ? load_edges[0] : -1, 17);

        // Asynchronous abort after 7 bits
        drive(1'b1, 1'b0, 1'b0);
        step();
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, w[N-1-i], 1'b1);
            step();
        end
        drive(1'b0, 1'b1, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_abort", {9'd0, load, busy, bit_cnt, dout}, 32'd0);
        #2;
        rst = 1'b1;
        mon_clear();
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'($urandom), 1'b1);
            step();
        end
        chk("abort_no_load", load_edges.size(), 0);
        chk("abort_idle", {30'd0, busy, |bit_cnt}, 32'd0);

        // Gapped word: three idle cycles after bits 4 and 11
        mon_clear();
        bad = 0;
        drive(1'b1, 1'b0, 1'b0);
        step();
        for (int i = 0; i < N; i++) begin
            drive(1'b0, w[N-1-i], 1'b1);
            step();
            if (i == 3 || i == 10) begin
                for (int g = 0; g < 3; g++) begin
                    drive(1'b0, 1'($urandom), 1'b0);
                    step();
                    if (busy !== 1'b1 || load !== 1'b0) bad++;
                end
            end
        end
        idle(2);
        chk("gap_busy_held", bad, 0);
        chk("gap_load_count", load_edges.size(), 1);
        chk("gap_load_edge", (load_edges.size() == 1) ? load_edges[0] : -1, 23);
        chk("gap_dout", (load_douts.size() == 1) ? load_douts[0] : 16'h0, 16'hA5C3);

        // Restart after 9 bits of ones; the bit coinciding with start is dropped
        mon_clear();
        drive(1'b1, 1'b0, 1'b0);
        step();
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, 1'b1, 1'b1);
            step();
        end
        drive(1'b1, 1'b1, 1'b1);
        step();
        chk("restart_cnt_busy", {26'd0, busy, bit_cnt}, {26'd0, 1'b1, 5'd0});
        send_word(16'h0001);
        idle(2);
        chk("restart_load_count", load_edges.size(), 1);
        chk("restart_dout", (load_douts.size() == 1) ? load_douts[0] : 16'hDEAD, 16'h0001);

        // Back-to-back words with start held during LOAD
        mon_clear();
        drive(1'b1, 1'b0, 1'b0);
        step();
        send_word(16'h1234);
        drive(1'b1, 1'b0, 1'b0);
        step();
        send_word(16'hFEDC);
        idle(2);
        chk("b2b_load_count", load_edges.size(), 2);
        chk("b2b_spacing", (load_edges.size() == 2) ? (load_edges[1] - load_edges[0]) : -1, 17);
        chk("b2b_dout0", (load_douts.size() == 2) ? load_douts[0] : 16'h0, 16'h1234);
        chk("b2b_dout1", (load_douts.size() == 2) ? load_douts[1] : 16'h0, 16'hFEDC);

        // Idle toggling without start must leave everything untouched
        mon_clear();
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            drive(1'b0, 1'($urandom), 1'($urandom));
            step();
            if (load !== 1'b0 || busy !== 1'b0 || dout !== 16'hFEDC) bad++;
        end
        chk("hold_bad_cycles", bad, 0);
        chk("hold_dout", dout, 16'hFEDC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
